// File: rtl/camera_capture_ctrl_pkg.sv
// Shared types and defaults for the OV7670 capture controller.
// Holds the FSM encoding, frame geometry defaults and RGB332 helpers.
package camera_capture_ctrl_pkg;

   localparam int DEF_SCREEN_WIDTH  = 176;
   localparam int DEF_SCREEN_HEIGHT = 144;
   localparam int DEF_ADDR_W        = 15;
   localparam int DEF_SYNC_STAGES   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FRAME = 2'd2,
      ST_DONE  = 2'd3
   } cap_state_t;

   localparam logic [7:0] RGB332_BLACK = 8'h00;
   localparam logic [7:0] RGB332_WHITE = 8'hFF;
   localparam logic [7:0] RGB332_RED   = 8'hE0;
   localparam logic [7:0] RGB332_GREEN = 8'h1C;
   localparam logic [7:0] RGB332_BLUE  = 8'h03;

   // rg holds {R[2:0],G[2:0]} from the RGB565 high byte; B comes from the low byte.
   function automatic logic [7:0] rgb332_pack(input logic [5:0] rg, input logic [7:0] lo_byte);
      return {rg, lo_byte[4:3]};
   endfunction

endpackage

// File: rtl/camera_capture_ctrl_if.sv
// Camera byte bus in, frame-buffer write port out.
// master = capture controller, slave = camera model / memory side.
interface camera_capture_ctrl_if #(
   parameter int ADDR_W = camera_capture_ctrl_pkg::DEF_ADDR_W
);
   logic              pclk;
   logic              href;
   logic              vsync;
   logic [7:0]        cam_data;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_data;
   logic              w_en;

   modport master (
      input  pclk, href, vsync, cam_data,
      output w_addr, w_data, w_en
   );

   modport slave (
      output pclk, href, vsync, cam_data,
      input  w_addr, w_data, w_en
   );
endinterface

// File: rtl/camera_capture_ctrl_sync_edge.sv
// Multi-flop synchroniser for one asynchronous camera signal,
// with rise/fall detection on the synchronised copy.
module cam_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sr;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr   <= '0;
         prev <= 1'b0;
      end else begin
         sr   <= {sr[STAGES-2:0], d};
         prev <= sr[STAGES-1];
      end
   end

   assign level = sr[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;
endmodule

// File: rtl/camera_capture_ctrl.sv
// OV7670 capture sequencer: synchronises the camera bus, packs RGB565 pairs
// into RGB332 and writes them frame-aligned into the frame buffer.
//
// state | meaning
// IDLE  | capture disabled
// ARMED | waiting for the start of a frame (VSYNC falling)
// FRAME | capturing lines into the frame buffer
// DONE  | one-cycle end-of-frame marker, FRAME_DONE high
module camera_capture_ctrl
   import camera_capture_ctrl_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   camera_capture_ctrl_if.master bus,
   input  logic                  capture_en,
   output logic                  frame_done,
   output logic                  line_err,
   output logic                  busy
);
   localparam int COL_W = $clog2(SCREEN_WIDTH + 1);
   localparam int ROW_W = $clog2(SCREEN_HEIGHT + 1);

   cap_state_t state, state_nxt;

   logic pclk_lvl, pclk_rise, pclk_fall;
   logic href_lvl, href_rise, href_fall;
   logic vsync_lvl, vsync_rise, vsync_fall;
   logic sync_unused;

   cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
      .clk(clk), .rst_n(rst_n), .d(bus.pclk),
      .level(pclk_lvl), .rise(pclk_rise), .fall(pclk_fall));

   cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
      .clk(clk), .rst_n(rst_n), .d(bus.href),
      .level(href_lvl), .rise(href_rise), .fall(href_fall));

   cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
      .clk(clk), .rst_n(rst_n), .d(bus.vsync),
      .level(vsync_lvl), .rise(vsync_rise), .fall(vsync_fall));

   assign sync_unused = ^{pclk_lvl, pclk_fall, href_rise};

   // Data follows the same number of flops as PCLK so it lines up with pclk_rise.
   logic [7:0] data_dly [SYNC_STAGES];
   logic [7:0] data_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) data_dly[i] <= '0;
      end else begin
         data_dly[0] <= bus.cam_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_dly[i] <= data_dly[i-1];
      end
   end

   assign data_s = data_dly[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (capture_en) state_nxt = ST_ARMED;
         ST_ARMED: begin
            if (!capture_en)     state_nxt = ST_IDLE;
            else if (vsync_fall) state_nxt = ST_FRAME;
         end
         ST_FRAME: if (vsync_rise) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = capture_en ? ST_ARMED : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign busy       = (state == ST_FRAME);
   assign frame_done = (state == ST_DONE);

   logic [COL_W-1:0]  col, col_eff;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] w_addr_q;
   logic [7:0]        w_data_q;
   logic              w_en_q;
   logic              phase, phase_eff;
   logic [5:0]        rg;
   logic              enter_frame, in_frame, byte_stb, pix_stb;
   logic              col_full, row_ok, pix_store, line_end, line_bad;

   assign enter_frame = (state == ST_ARMED) && (state_nxt == ST_FRAME);
   // A VSYNC rise ends the frame in this very cycle, so nothing is captured alongside it.
   assign in_frame    = (state == ST_FRAME) && !vsync_lvl;
   // HREF falling together with a byte still counts that byte as part of the line.
   assign byte_stb    = in_frame && (href_lvl || href_fall) && pclk_rise;
   assign pix_stb     = byte_stb && phase;
   assign col_full    = (col == COL_W'(SCREEN_WIDTH));
   assign row_ok      = (row < ROW_W'(SCREEN_HEIGHT));
   assign pix_store   = pix_stb && !col_full && row_ok;
   assign col_eff     = (pix_stb && !col_full) ? col + COL_W'(1) : col;
   assign phase_eff   = byte_stb ? ~phase : phase;
   assign line_end    = in_frame && href_fall;
   assign line_bad    = (col_eff != COL_W'(SCREEN_WIDTH)) || phase_eff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         line_base <= '0;
         phase     <= 1'b0;
         rg        <= '0;
         w_addr_q  <= '0;
         w_data_q  <= '0;
         w_en_q    <= 1'b0;
         line_err  <= 1'b0;
      end else begin
         w_en_q <= 1'b0;
         if (enter_frame) begin
            col       <= '0;
            row       <= '0;
            line_base <= '0;
            phase     <= 1'b0;
            line_err  <= 1'b0;
         end else if (in_frame) begin
            if (byte_stb) begin
               phase <= ~phase;
               if (!phase) rg <= {data_s[7:5], data_s[2:0]};
            end
            if (pix_store) begin
               w_en_q   <= 1'b1;
               w_addr_q <= line_base + ADDR_W'(col);
               w_data_q <= rgb332_pack(rg, data_s);
            end
            if (pix_stb && !col_full) col <= col + COL_W'(1);
            if (pix_stb && col_full)  line_err <= 1'b1;
            if (line_end) begin
               col   <= '0;
               phase <= 1'b0;
               if (line_bad) line_err <= 1'b1;
               if (row_ok) begin
                  row       <= row + ROW_W'(1);
                  line_base <= line_base + ADDR_W'(SCREEN_WIDTH);
               end
            end
         end
      end
   end

   assign bus.w_addr = w_addr_q;
   assign bus.w_data = w_data_q;
   assign bus.w_en   = w_en_q;
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed bench for camera_capture_ctrl using a reduced 8x4 frame so that
// whole frames fit in a short run; frame-level vectors plus corner sequences.
module tb_camera_capture_ctrl;
   import camera_capture_ctrl_pkg::*;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int AW = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic capture_en = 1'b0;
   logic frame_done, line_err, busy;

   camera_capture_ctrl_if #(.ADDR_W(AW)) bus ();

   camera_capture_ctrl #(
      .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(AW), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .capture_en(capture_en),
      .frame_done(frame_done), .line_err(line_err), .busy(busy)
   );

   always #10 clk = ~clk;

   int wr_addr_q[$];
   int wr_data_q[$];
   int fd_cnt   = 0;
   int max_addr = 0;

   always @(negedge clk) begin
      if (bus.w_en) begin
         wr_addr_q.push_back(int'(bus.w_addr));
         wr_data_q.push_back(int'(bus.w_data));
         if (int'(bus.w_addr) > max_addr) max_addr = int'(bus.w_addr);
      end
      if (frame_done) fd_cnt++;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.cam_data = b;
      bus.pclk = 1'b0;
      cyc(2);
      bus.pclk = 1'b1;
      cyc(2);
   endtask

   task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                            input bit coincide);
      bus.href = 1'b1;
      cyc(2);
      for (int i = 0; i < nbytes; i++) begin
         bus.cam_data = (i % 2 == 0) ? b0 : b1;
         bus.pclk = 1'b0;
         cyc(2);
         bus.pclk = 1'b1;
         if (coincide && i == nbytes - 1) bus.href = 1'b0;
         cyc(2);
      end
      bus.pclk = 1'b0;
      bus.href = 1'b0;
      cyc(6);
   endtask

   task automatic frame_start();
      bus.vsync = 1'b0;
      cyc(8);
   endtask

   task automatic frame_end();
      bus.vsync = 1'b1;
      cyc(10);
   endtask

   task automatic run_frame(input int nlines, input int l0, input int rest,
                            input logic [7:0] b0, input logic [7:0] b1);
      frame_start();
      for (int r = 0; r < nlines; r++) send_line((r == 0) ? l0 : rest, b0, b1, 1'b0);
      frame_end();
   endtask

   typedef struct {
      int         nlines;
      int         bytes_l0;
      int         bytes_rest;
      logic [7:0] b0;
      logic [7:0] b1;
      int         exp_writes;
      logic [7:0] exp_data;
      int         exp_last;
      bit         exp_err;
   } frame_vec_t;

   frame_vec_t vecs [7];

   // Expected address order derived from the line lengths of one frame.
   task automatic check_frame(input int v, input int base, input int fd_base, input frame_vec_t fv);
      int exp_q[$];
      int n, amis, dmis, px;
      for (int r = 0; r < fv.nlines; r++) begin
         px = ((r == 0) ? fv.bytes_l0 : fv.bytes_rest) / 2;
         if (r < H)
            for (int k = 0; k < px && k < W; k++) exp_q.push_back(r * W + k);
      end
      n = wr_addr_q.size() - base;
      chk($sformatf("v%0d wr_count", v), n, fv.exp_writes);
      amis = 0;
      dmis = 0;
      for (int i = 0; i < n; i++) begin
         if (i >= exp_q.size() || wr_addr_q[base + i] != exp_q[i]) amis++;
         if (wr_data_q[base + i] != int'(fv.exp_data)) dmis++;
      end
      chk($sformatf("v%0d addr_seq_mismatches", v), amis, 0);
      chk($sformatf("v%0d data_mismatches", v), dmis, 0);
      chk($sformatf("v%0d last_addr", v), (n > 0) ? wr_addr_q[wr_addr_q.size() - 1] : -1, fv.exp_last);
      chk($sformatf("v%0d line_err", v), int'(line_err), int'(fv.exp_err));
      chk($sformatf("v%0d frame_done_pulses", v), fd_cnt - fd_base, 1);
      chk($sformatf("v%0d busy_after", v), int'(busy), 0);
   endtask

   initial begin
      int base, fdb, seen;

      vecs[0] = '{4, 16, 16, 8'hE7, 8'h18, 32, 8'hFF, 31, 1'b0};
      vecs[1] = '{2, 20, 16, 8'hE7, 8'h18, 16, 8'hFF, 15, 1'b1};
      vecs[2] = '{2, 12, 16, 8'hE7, 8'h18, 14, 8'hFF, 15, 1'b1};
      vecs[3] = '{2, 15, 16, 8'h20, 8'h08, 15, 8'h21, 15, 1'b1};
      vecs[4] = '{6, 16, 16, 8'hA5, 8'h10, 32, 8'hB6, 31, 1'b0};
      vecs[5] = '{1, 16, 16, 8'h00, 8'h00,  8, 8'h00,  7, 1'b0};
      vecs[6] = '{3, 16, 14, 8'h1F, 8'hE7, 22, 8'h1C, 22, 1'b1};

      bus.pclk = 1'b0;
      bus.href = 1'b0;
      bus.vsync = 1'b1;
      bus.cam_data = 8'h00;

      cyc(5);
      chk("rst w_en", int'(bus.w_en), 0);
      chk("rst w_addr", int'(bus.w_addr), 0);
      chk("rst w_data", int'(bus.w_data), 0);
      chk("rst frame_done", int'(frame_done), 0);
      chk("rst line_err", int'(line_err), 0);
      chk("rst busy", int'(busy), 0);
      rst_n = 1'b1;
      cyc(3);

      // VSYNC activity while disarmed must be ignored.
      base = wr_addr_q.size();
      fdb  = fd_cnt;
      run_frame(1, 16, 16, 8'hE7, 8'h18);
      chk("idle writes", wr_addr_q.size() - base, 0);
      chk("idle frame_done", fd_cnt - fdb, 0);

      // Arming while VSYNC is already low must not start mid-frame.
      bus.vsync = 1'b0;
      cyc(8);
      capture_en = 1'b1;
      cyc(4);
      send_line(16, 8'hE7, 8'h18, 1'b0);
      chk("midframe arm busy", int'(busy), 0);
      frame_end();
      chk("midframe arm writes", wr_addr_q.size() - base, 0);
      chk("midframe arm frame_done", fd_cnt - fdb, 0);

      for (int v = 0; v < 7; v++) begin
         base = wr_addr_q.size();
         fdb  = fd_cnt;
         run_frame(vecs[v].nlines, vecs[v].bytes_l0, vecs[v].bytes_rest, vecs[v].b0, vecs[v].b1);
         check_frame(v, base, fdb, vecs[v]);
      end

      // HREF falling in the same cycle as the completing byte.
      base = wr_addr_q.size();
      frame_start();
      send_line(16, 8'hE7, 8'h18, 1'b1);
      send_line(16, 8'hE7, 8'h18, 1'b0);
      frame_end();
      chk("coincide writes", wr_addr_q.size() - base, 16);
      chk("coincide last_addr", wr_addr_q[wr_addr_q.size() - 1], 15);
      chk("coincide line_err", int'(line_err), 0);

      // VSYNC rising while HREF is high with a half pixel pending.
      base = wr_addr_q.size();
      fdb  = fd_cnt;
      frame_start();
      bus.href = 1'b1;
      cyc(2);
      send_byte(8'hE7);
      send_byte(8'h18);
      send_byte(8'hE7);
      bus.vsync = 1'b1;
      cyc(10);
      bus.href = 1'b0;
      bus.pclk = 1'b0;
      cyc(6);
      chk("vs_href writes", wr_addr_q.size() - base, 1);
      chk("vs_href frame_done", fd_cnt - fdb, 1);
      base = wr_addr_q.size();
      run_frame(1, 16, 16, 8'hE7, 8'h18);
      chk("after vs_href writes", wr_addr_q.size() - base, 8);
      chk("after vs_href first_addr", wr_addr_q[base], 0);
      chk("after vs_href data", wr_data_q[base], 8'hFF);

      // Disarm in the middle of a frame.
      base = wr_addr_q.size();
      fdb  = fd_cnt;
      frame_start();
      chk("busy in frame", int'(busy), 1);
      send_line(16, 8'hE7, 8'h18, 1'b0);
      send_line(16, 8'hE7, 8'h18, 1'b0);
      capture_en = 1'b0;
      send_line(16, 8'hE7, 8'h18, 1'b0);
      send_line(16, 8'hE7, 8'h18, 1'b0);
      frame_end();
      chk("disarm writes", wr_addr_q.size() - base, 32);
      chk("disarm frame_done", fd_cnt - fdb, 1);
      base = wr_addr_q.size();
      fdb  = fd_cnt;
      frame_start();
      chk("disarm next busy", int'(busy), 0);
      send_line(16, 8'hE7, 8'h18, 1'b0);
      frame_end();
      chk("disarm next writes", wr_addr_q.size() - base, 0);
      chk("disarm next frame_done", fd_cnt - fdb, 0);

      // Reset while a write strobe is high.
      capture_en = 1'b1;
      cyc(4);
      frame_start();
      bus.href = 1'b1;
      cyc(2);
      for (int i = 0; i < 9; i++) send_byte((i % 2 == 0) ? 8'hE7 : 8'h18);
      bus.cam_data = 8'h18;
      bus.pclk = 1'b0;
      cyc(2);
      bus.pclk = 1'b1;
      seen = 0;
      for (int k = 0; k < 8 && seen == 0; k++) begin
         if (bus.w_en) seen = 1;
         else cyc(1);
      end
      chk("rst_mid w_en observed", seen, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid w_en", int'(bus.w_en), 0);
      chk("rst_mid busy", int'(busy), 0);
      cyc(3);
      rst_n = 1'b1;
      base = wr_addr_q.size();
      for (int i = 0; i < 6; i++) send_byte((i % 2 == 0) ? 8'hE7 : 8'h18);
      bus.href = 1'b0;
      bus.pclk = 1'b0;
      cyc(6);
      frame_end();
      chk("rst_mid leftover writes", wr_addr_q.size() - base, 0);
      base = wr_addr_q.size();
      run_frame(4, 16, 16, 8'hE7, 8'h18);
      chk("rst_mid next writes", wr_addr_q.size() - base, 32);
      chk("rst_mid next first_addr", (wr_addr_q.size() > base) ? wr_addr_q[base] : -1, 0);

      chk("max_addr in range", int'(max_addr <= W * H - 1), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
